pb_event_scanner: RTL and testbench
===================================

# pb_event_scanner

Debounces the five shared LCD-data/RS lines that double as push-button inputs and turns debounced transitions into a stream of press/release events for the control CPU's `pb_in` input. Sits between the LCD tri-state pads and the `main_0` control-software block in the `clk_50` domain. Sampling is suppressed while the LCD driver owns the pins, and for a settle window after it releases them.

## Interface
- `CLOCK_FREQUENCY`, 50000000, informational only; not used in arithmetic.
- `DEBOUNCE_CYCLES`, 500000, consecutive enabled cycles a new level must persist before it is committed (10 ms at 50 MHz); must be ≥ 8.
- `SETTLE_CYCLES`, 64, freeze length after `lcd_oe` falls and after reset release; must be ≥ 1.
- `FIFO_DEPTH`, 4, event FIFO entries; must be a power of two.

Ports:
- `clk`  in  1  system clock (`clk_50`).
- `rst`  in  1  reset. Asynchronous, active-high.
- `pb_in`  in  5  raw pad levels, active-low buttons: [3:0] = `lcd_data`, [4] = `lcd_rs`.
- `lcd_oe`  in  1  LCD driver is driving the shared pins.
- `pb_state_out`  out  5  debounced button state, 1 = pressed.
- `event_out`  out  32  head event: [2:0] button index, [8] 1 = press / 0 = release, [31:24] sequence number, all other bits 0.
- `event_stb_out`  out  1  `event_out` is valid.
- `event_ack_in`  in  1  consumer accepts the head event.
- `overflow_out`  out  1  sticky flag: at least one event was dropped.

## Operation
- **Synchroniser.** Two flops per line. They reset to 1 (released). `raw[i] = ~sync[i]`.
- **Freeze.**
  - Freeze is active while `lcd_oe`=1.
  - Freeze is also active for SETTLE_CYCLES cycles after `lcd_oe` falls, and for SETTLE_CYCLES cycles after reset deasserts.
  - The settle counter reloads on every cycle where `lcd_oe`=1.
  - While frozen, debounce counters and `pb_state_out` hold.
- **Debounce, per channel, each enabled cycle.**
  - If `raw == stable`: the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and raw still differs: `stable <= raw`, the counter clears, and `pending[i]` is set.
  - The counter width is `clog2(DEBOUNCE_CYCLES)`; it never wraps.
- **Enqueue engine, one event per cycle.**
  - Selects the lowest-index set `pending` bit.
  - Builds the event from the index, `stable[i]`, and `seq`.
  - Clears that `pending` bit and increments `seq` (8 bits, wraps 255→0).
  - The write succeeds if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the event is discarded and `overflow_out` is set.
  - `seq` increments on dropped events too, so the consumer can see gaps.
- **Output handshake.**
  - `event_stb_out` = FIFO non-empty.
  - `event_out` is the head entry and is held stable while stb=1 and ack=0.
  - A pop occurs on a cycle with stb & ack. `event_ack_in` is ignored while stb=0.
- **Reset values.**
  - `pb_state_out`=0, `event_out`=0, `event_stb_out`=0, `overflow_out`=0.
  - FIFO empty, `pending`=0, `seq`=0, counters 0.
  - Reset mid-operation discards all queued and pending events. `overflow_out` clears only on reset.

## Timing
- **Pin to state.** Let edge 0 be the first clock edge sampling the new pad level, with the level held steady and no freeze. `pb_state_out[i]` changes on edge 2+DEBOUNCE_CYCLES-1.
- **State to event.** `pending` is set on the same edge. The event is written on the following edge (assuming no lower-index pending). `event_stb_out` rises one cycle after `pb_state_out` when the FIFO was empty.
- **Simultaneous commits.** Several channels committing on one edge are enqueued on successive cycles in ascending index order.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES enabled cycles produces no state change and no event.
- **Freeze interaction.** A freeze mid-count extends the count. It does not restart it.
- **FIFO throughput.** Full throughput: one push and one pop per cycle.

## Test plan
Bench uses DEBOUNCE_CYCLES=16, SETTLE_CYCLES=4, FIFO_DEPTH=4.
- **Single press.** Drive `pb_in[2]` low and hold, with `lcd_oe`=0 after settle → `pb_state_out`=5'b00100 exactly 17 edges after the first sampling edge; then one event 0x00000102 with stb; ack pops it and stb falls.
- **Bounce rejection.**
  - Toggle `pb_in[0]` low for 10 cycles and high for 3, repeated 5 times → no change on `pb_state_out` and no event.
  - Then hold low → press event with seq 0.
- **LCD ownership.**
  - Press `pb_in[1]` while `lcd_oe`=1 for 100 cycles → no event.
  - Drop `lcd_oe` → press event appears 4+2+16 cycles later.
- **Simultaneous commits.** Release `pb_in[4]` and `pb_in[3]` on the same cycle (both previously pressed) → events index 3 then index 4, both with [8]=0, consecutive seq values.
- **Overflow.**
  - Hold ack=0 and generate 6 events → FIFO holds the first 4 (seq 0–3); `overflow_out`=1.
  - Draining yields seq 0,1,2,3; the next event carries seq 6.
- **Async reset mid-queue.** Assert `rst` for 1 ns between edges with 2 events queued → all outputs return to 0 immediately; no events appear after release until a new debounced change.

Source files
------------

// File: rtl/pb_event_scanner.sv
// Debounces the shared LCD-data/RS pads used as push-buttons and queues
// press/release events for the control CPU, ignoring the pins while the LCD owns them.
module pb_event_scanner #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 64,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  pb_in,
    input  logic        lcd_oe,
    output logic [4:0]  pb_state_out,
    output logic [31:0] event_out,
    output logic        event_stb_out,
    input  logic        event_ack_in,
    output logic        overflow_out
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    if (DEBOUNCE_CYCLES < 8 || SETTLE_CYCLES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLOCK_FREQUENCY <= 0) begin : g_bad_params
        $error("pb_event_scanner: illegal parameter set");
    end

    logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [4:0]    stable_q, stable_d;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];
    logic [4:0]    pending_q, pending_d;
    logic [7:0]    seq_q, seq_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    logic [4:0]    raw;
    logic          freeze;
    logic          sel_valid, sel_level;
    logic [2:0]    sel_idx;
    logic [4:0]    sel_mask;
    logic [31:0]   new_event;
    logic          empty, full, pop, push;

    always_comb begin
        sync1_d    = pb_in;
        sync2_d    = sync1_q;
        raw        = ~sync2_q;
        settle_d   = settle_q;
        stable_d   = stable_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;

        // Settle window keeps the pins frozen for a while after the LCD lets go.
        if (lcd_oe)
            settle_d = SETTLE_LOAD;
        else if (settle_q != '0)
            settle_d = settle_q - SW'(1);
        freeze = lcd_oe || (settle_q != '0);

        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_level = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 3'(i);
                sel_level = stable_q[i];
            end
        end
        sel_mask  = sel_valid ? (5'd1 << sel_idx) : 5'd0;
        new_event = {seq_q, 15'd0, sel_level, 5'd0, sel_idx};
        pending_d = pending_q & ~sel_mask;
        if (sel_valid)
            seq_d = seq_q + 8'd1;

        // A fresh commit sets its pending bit after the enqueue clear, so it is never lost.
        if (!freeze) begin
            for (int i = 0; i < 5; i++) begin
                if (raw[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i]  = raw[i];
                    cnt_d[i]     = '0;
                    pending_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end

        empty = (wr_ptr_q == rd_ptr_q);
        full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
        pop   = !empty && event_ack_in;
        push  = sel_valid && (!full || pop);
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = new_event;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (sel_valid && !push)
            overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 5'h1F;
            sync2_q    <= 5'h1F;
            settle_q   <= SETTLE_LOAD;
            stable_q   <= '0;
            for (int i = 0; i < 5; i++)
                cnt_q[i] <= '0;
            pending_q  <= '0;
            seq_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            settle_q   <= settle_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            seq_q      <= seq_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign pb_state_out  = stable_q;
    assign event_stb_out = !empty;
    assign event_out     = empty ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_out  = overflow_q;

endmodule

// File: tb/tb_pb_event_scanner.sv
// Bench for pb_event_scanner: directed vector table, hand-written corner
// sequences, and random stimulus against a queue-based reference model.
module tb_pb_event_scanner;
    localparam int D = 16;
    localparam int S = 4;
    localparam int F = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  pb_in = 5'h1F;
    logic        lcd_oe = 1'b0;
    logic        event_ack_in = 1'b0;
    logic [4:0]  pb_state_out;
    logic [31:0] event_out;
    logic        event_stb_out;
    logic        overflow_out;

    int n_checks = 0;
    int n_pass   = 0;

    pb_event_scanner #(
        .CLOCK_FREQUENCY(50000000),
        .DEBOUNCE_CYCLES(D),
        .SETTLE_CYCLES(S),
        .FIFO_DEPTH(F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pb_in(pb_in),
        .lcd_oe(lcd_oe),
        .pb_state_out(pb_state_out),
        .event_out(event_out),
        .event_stb_out(event_stb_out),
        .event_ack_in(event_ack_in),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: pad history, ownership timestamp, run-lengths and an event queue.
    logic [4:0]  m_h0, m_h1, m_state, m_pend, m_level;
    int          m_run [5];
    logic [7:0]  m_seq;
    logic [31:0] m_q [$];
    logic        m_ovf;
    int          m_edge, m_own, m_k;
    bit          m_frozen;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_h0 = 5'h1F; m_h1 = 5'h1F; m_state = '0; m_pend = '0;
                m_seq = '0; m_ovf = 1'b0; m_edge = 0; m_own = 0;
                m_q.delete();
                for (int i = 0; i < 5; i++) m_run[i] = 0;
            end else begin
                m_edge++;
                if (lcd_oe) m_own = m_edge;
                m_frozen = (m_edge - m_own) <= S;
                m_level = ~m_h1;
                if (m_q.size() != 0 && event_ack_in) void'(m_q.pop_front());
                if (m_pend != '0) begin
                    m_k = 0;
                    for (int i = 4; i >= 0; i--) if (m_pend[i]) m_k = i;
                    if (m_q.size() < F)
                        m_q.push_back({m_seq, 15'd0, m_state[m_k], 5'd0, 3'(m_k)});
                    else
                        m_ovf = 1'b1;
                    m_pend[m_k] = 1'b0;
                    m_seq = m_seq + 8'd1;
                end
                if (!m_frozen) begin
                    for (int i = 0; i < 5; i++) begin
                        if (m_level[i] == m_state[i]) begin
                            m_run[i] = 0;
                        end else begin
                            m_run[i]++;
                            if (m_run[i] == D) begin
                                m_state[i] = m_level[i];
                                m_run[i]   = 0;
                                m_pend[i]  = 1'b1;
                            end
                        end
                    end
                end
                m_h1 = m_h0;
                m_h0 = pb_in;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic do_reset();
        pb_in = 5'h1F; lcd_oe = 1'b0; event_ack_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (S + 1) @(negedge clk);
    endtask

    task automatic change_and_check(input int btn, input logic pad, input logic [4:0] exp_state,
                                    input logic [31:0] exp_ev, input string tag);
        logic [4:0] prev_state;
        prev_state = exp_state ^ (5'd1 << btn);
        pb_in[btn] = pad;
        repeat (D + 1) @(negedge clk);
        check({tag, " state before commit edge"}, 32'(pb_state_out), 32'(prev_state));
        @(negedge clk);
        check({tag, " state at commit edge"}, 32'(pb_state_out), 32'(exp_state));
        check({tag, " stb at commit edge"}, 32'(event_stb_out), 32'd0);
        @(negedge clk);
        check({tag, " stb"}, 32'(event_stb_out), 32'd1);
        check({tag, " event"}, event_out, exp_ev);
        event_ack_in = 1'b1;
        @(negedge clk);
        event_ack_in = 1'b0;
        check({tag, " stb after ack"}, 32'(event_stb_out), 32'd0);
    endtask

    task automatic pop_expect(input logic [31:0] exp_ev, input string tag);
        int n;
        n = 0;
        while (!event_stb_out && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, " stb"}, 32'(event_stb_out), 32'd1);
        check({tag, " event"}, event_out, exp_ev);
        event_ack_in = 1'b1;
        @(negedge clk);
        event_ack_in = 1'b0;
    endtask

    typedef struct {
        int          btn;
        logic        pad;
        logic [4:0]  exp_state;
        logic [31:0] exp_ev;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int bad, n, errs;
        logic [38:0] got, exp;

        vecs[0] = '{0, 1'b0, 5'b00101, 32'h01000100};
        vecs[1] = '{4, 1'b0, 5'b10101, 32'h02000104};
        vecs[2] = '{2, 1'b1, 5'b10001, 32'h03000002};
        vecs[3] = '{3, 1'b0, 5'b11001, 32'h04000103};
        vecs[4] = '{0, 1'b1, 5'b11000, 32'h05000000};
        vecs[5] = '{1, 1'b0, 5'b11010, 32'h06000101};

        @(negedge clk);
        check("reset state", 32'(pb_state_out), 32'd0);
        check("reset event", event_out, 32'd0);
        check("reset stb", 32'(event_stb_out), 32'd0);
        check("reset overflow", 32'(overflow_out), 32'd0);
        do_reset();

        change_and_check(2, 1'b0, 5'b00100, 32'h00000102, "single press");
        for (int v = 0; v < 6; v++)
            change_and_check(vecs[v].btn, vecs[v].pad, vecs[v].exp_state, vecs[v].exp_ev,
                             $sformatf("vec%0d", v));

        // Bounce rejection
        do_reset();
        bad = 0;
        for (int r = 0; r < 5; r++) begin
            pb_in[0] = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (pb_state_out != 5'd0 || event_stb_out) bad = 1;
            end
            pb_in[0] = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (pb_state_out != 5'd0 || event_stb_out) bad = 1;
            end
        end
        check("bounce quiet", 32'(bad), 32'd0);
        change_and_check(0, 1'b0, 5'b00001, 32'h00000100, "bounce hold");

        // LCD ownership
        do_reset();
        lcd_oe = 1'b1;
        pb_in[1] = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pb_state_out != 5'd0 || event_stb_out) bad = 1;
        end
        check("lcd owned quiet", 32'(bad), 32'd0);
        lcd_oe = 1'b0;
        n = 0;
        while (!event_stb_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lcd release latency in window", 32'((n - 1 >= S + D) && (n - 1 <= S + 2 + D)), 32'd1);
        check("lcd state", 32'(pb_state_out), 32'b00010);
        pop_expect(32'h00000101, "lcd event");

        // Simultaneous commits
        do_reset();
        pb_in[4:3] = 2'b00;
        pop_expect(32'h00000103, "simul press3");
        pop_expect(32'h01000104, "simul press4");
        pb_in[4:3] = 2'b11;
        pop_expect(32'h02000003, "simul release3");
        pop_expect(32'h03000004, "simul release4");
        check("simul state", 32'(pb_state_out), 32'd0);

        // Overflow
        do_reset();
        pb_in = 5'h00;
        repeat (D + 8) @(negedge clk);
        check("ovf all pressed", 32'(pb_state_out), 32'h1F);
        pb_in[0] = 1'b1;
        repeat (D + 6) @(negedge clk);
        check("ovf flag", 32'(overflow_out), 32'd1);
        pop_expect(32'h00000100, "ovf drain0");
        pop_expect(32'h01000101, "ovf drain1");
        pop_expect(32'h02000102, "ovf drain2");
        pop_expect(32'h03000103, "ovf drain3");
        check("ovf drained", 32'(event_stb_out), 32'd0);
        pb_in[1] = 1'b1;
        pop_expect(32'h06000001, "ovf next seq");
        check("ovf sticky", 32'(overflow_out), 32'd1);

        // Async reset mid-queue
        do_reset();
        check("ovf cleared by reset", 32'(overflow_out), 32'd0);
        pb_in[1:0] = 2'b00;
        repeat (D + 4) @(negedge clk);
        check("two queued", 32'(event_stb_out), 32'd1);
        pb_in = 5'h1F;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst state", 32'(pb_state_out), 32'd0);
        check("async rst event", event_out, 32'd0);
        check("async rst stb", 32'(event_stb_out), 32'd0);
        check("async rst overflow", 32'(overflow_out), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (pb_state_out != 5'd0 || event_stb_out) bad = 1;
        end
        check("quiet after async rst", 32'(bad), 32'd0);

        // Random stimulus against the model
        do_reset();
        errs = 0;
        n = 0;
        for (int cyc = 0; cyc < 5000 && errs < 10; cyc++) begin
            if ($urandom_range(0, (cyc < 2500) ? 39 : 7) == 0)
                pb_in[$urandom_range(0, 4)] = ~pb_in[$urandom_range(0, 4)];
            if (n > 0) begin
                n--;
                lcd_oe = 1'b1;
            end else begin
                lcd_oe = 1'b0;
                if ($urandom_range(0, 199) == 0) n = $urandom_range(1, 30);
            end
            event_ack_in = ($urandom_range(0, 99) < ((cyc % 1000) < 300 ? 5 : 60));
            @(negedge clk);
            got = {pb_state_out, event_stb_out, overflow_out, event_out};
            exp = {m_state, m_q.size() != 0, m_ovf, (m_q.size() != 0) ? m_q[0] : 32'd0};
            n_checks++;
            if (got === exp) begin
                n_pass++;
            end else begin
                errs++;
                $display("FAIL random cycle %0d: got state=%b stb=%b ovf=%b ev=0x%08h, want state=%b stb=%b ovf=%b ev=0x%08h",
                         cyc, got[38:34], got[33], got[32], got[31:0], exp[38:34], exp[33], exp[32], exp[31:0]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
